ws2812_tx: RTL and testbench

WS2812_TX -- requirements
Module: ws2812_tx

---
 rtl/ws2812_pkg.sv | 25 ++
 rtl/ws2812_bit_enc.sv | 58 +++++
 rtl/ws2812_tx.sv | 147 ++++++++++++++
 tb/tb_ws2812_tx.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared state encoding, default timing constants and counter sizing helper for the WS2812 transmitter.
package ws2812_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        LATCH = 3'd4
    } state_t;

    localparam int DEF_NLED   = 1;
    localparam int DEF_T0H    = 40;
    localparam int DEF_T1H    = 80;
    localparam int DEF_TBIT   = 125;
    localparam int DEF_TRESET = 5000;

    // Width that holds the larger of two cycle counts without wrapping.
    function automatic int ctr_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ws2812_bit_enc.sv
// Single-bit waveform generator: on go, drives the line high for T1H/T0H cycles
// and low for the rest of a TBIT-cycle period, flagging bit_done on the last cycle.
module ws2812_bit_enc
    import ws2812_pkg::*;
#(
    parameter int T0H  = DEF_T0H,
    parameter int T1H  = DEF_T1H,
    parameter int TBIT = DEF_TBIT,
    parameter int CW   = ctr_width(DEF_TBIT, DEF_TRESET)
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic bit_val,
    output logic line,
    output logic bit_done
);

    logic          active_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] th_r;
    logic          line_r;

    // End of the bit period is the last counted cycle of an active bit.
    always_comb begin
        bit_done = active_r && (cnt_r == CW'(TBIT - 1));
    end

    // Bit timer; a new go on the final cycle starts the next bit back to back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_r <= 1'b0;
            cnt_r    <= '0;
            th_r     <= '0;
            line_r   <= 1'b0;
        end else if (go) begin
            active_r <= 1'b1;
            cnt_r    <= '0;
            th_r     <= bit_val ? CW'(T1H) : CW'(T0H);
            line_r   <= 1'b1;
        end else if (active_r) begin
            if (bit_done) begin
                active_r <= 1'b0;
                cnt_r    <= '0;
                line_r   <= 1'b0;
            end else begin
                cnt_r  <= cnt_r + CW'(1);
                line_r <= (cnt_r + CW'(1)) < th_r;
            end
        end else begin
            cnt_r  <= '0;
            line_r <= 1'b0;
        end
    end

    assign line = line_r;

endmodule

// File: rtl/ws2812_tx.sv
// WS2812 frame transmitter: streams 3*nled bytes (G,R,B per LED) MSB first, then latches.
// Optional macro WS2812_AUTO_REFRESH_EN restarts the frame automatically after each latch.
module ws2812_tx
    import ws2812_pkg::*;
#(
    parameter int nled   = DEF_NLED,
    parameter int T0H    = DEF_T0H,
    parameter int T1H    = DEF_T1H,
    parameter int TBIT   = DEF_TBIT,
    parameter int TRESET = DEF_TRESET
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       ws2812_out
);

    localparam int         CW        = ctr_width(TBIT, TRESET);
    localparam logic [7:0] LAST_ADDR = 8'(3 * nled - 1);

    state_t        state_r, state_s;
    logic [7:0]    shreg_r, shreg_s;
    logic [2:0]    bit_cnt_r, bit_cnt_s;
    logic [7:0]    rd_addr_r, rd_addr_s;
    logic [CW-1:0] latch_cnt_r, latch_cnt_s;
    logic          busy_r, done_r, done_s;
    logic          go_s, bit_val_s, line_s, bit_done_s;

    ws2812_bit_enc #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT),
        .CW   (CW)
    ) u_bit_enc (
        .clk      (clk),
        .rst      (rst),
        .go       (go_s),
        .bit_val  (bit_val_s),
        .line     (line_s),
        .bit_done (bit_done_s)
    );

    // Next-state and datapath decode; the shift register holds the bits still to send.
    always_comb begin
        state_s     = state_r;
        shreg_s     = shreg_r;
        bit_cnt_s   = bit_cnt_r;
        rd_addr_s   = rd_addr_r;
        latch_cnt_s = latch_cnt_r;
        done_s      = 1'b0;
        go_s        = 1'b0;
        bit_val_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s   = LOAD;
                    rd_addr_s = 8'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                shreg_s   = {rd_data[6:0], 1'b0};
                bit_cnt_s = 3'd7;
                go_s      = 1'b1;
                bit_val_s = rd_data[7];
                state_s   = HIGH;
            end
            HIGH, LOW: begin
                if (bit_done_s) begin
                    if (bit_cnt_r != 3'd0) begin
                        shreg_s   = {shreg_r[6:0], 1'b0};
                        bit_cnt_s = bit_cnt_r - 3'd1;
                        go_s      = 1'b1;
                        bit_val_s = shreg_r[7];
                        state_s   = HIGH;
                    end else if (rd_addr_r < LAST_ADDR) begin
                        rd_addr_s = rd_addr_r + 8'd1;
                        state_s   = LOAD;
                    end else begin
                        latch_cnt_s = '0;
                        state_s     = LATCH;
                    end
                end else if (!line_s) begin
                    state_s = LOW;
                end else begin
                    state_s = state_r;
                end
            end
            LATCH: begin
                if (latch_cnt_r == CW'(TRESET - 1)) begin
                    done_s      = 1'b1;
                    latch_cnt_s = '0;
                    rd_addr_s   = 8'd0;
`ifdef WS2812_AUTO_REFRESH_EN
                    state_s     = LOAD;
`else
                    state_s     = IDLE;
`endif
                end else begin
                    latch_cnt_s = latch_cnt_r + CW'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_r     <= 8'd0;
            bit_cnt_r   <= 3'd0;
            rd_addr_r   <= 8'd0;
            latch_cnt_r <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            shreg_r     <= shreg_s;
            bit_cnt_r   <= bit_cnt_s;
            rd_addr_r   <= rd_addr_s;
            latch_cnt_r <= latch_cnt_s;
            busy_r      <= (state_s != IDLE);
            done_r      <= done_s;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign rd_addr    = rd_addr_r;
    assign ws2812_out = line_s;

endmodule

// File: tb/tb_ws2812_tx.sv
// Directed bench for ws2812_tx: default-timing single-LED frames and a fast-timed 85-LED frame.
module tb_ws2812_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b;
    logic       busy_a, done_a, ws_a, busy_b, done_b, ws_b;
    logic [7:0] rd_addr_a, rd_data_a, rd_addr_b, rd_data_b;

    int errors = 0;
    int checks = 0;

    int          n_rise, n_done, done_cyc, bad_bits, hi0, hi1, rise0;
    logic [23:0] bits_got;
    logic        busy0;

    always #5 clk = ~clk;

    assign rd_data_a = (rd_addr_a == 8'd0) ? 8'h41 :
                       (rd_addr_a == 8'd1) ? 8'h20 :
                       (rd_addr_a == 8'd2) ? 8'hC0 : 8'h00;
    assign rd_data_b = rd_addr_b;

    ws2812_tx dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a), .ws2812_out(ws_a)
    );

    ws2812_tx #(.nled(85), .T0H(1), .T1H(2), .TBIT(4), .TRESET(10)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .ws2812_out(ws_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Watch dut_a for ncyc cycles (cycle 0 = first negedge after start is sampled).
    task automatic cap_a(input int ncyc, input bit hold);
        int  hi;
        int  k;
        bit  prev;
        n_rise = 0; n_done = 0; done_cyc = -1; bad_bits = 0; bits_got = '0;
        hi0 = 0; hi1 = 0; rise0 = -1; hi = 0; prev = 1'b0; busy0 = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (!hold) start_a = 1'b0;
            if (c == 0) busy0 = busy_a;
            if (ws_a && !prev) begin
                if (c != 1 + n_rise * 125 + n_rise / 8) bad_bits++;
                if (n_rise == 0) rise0 = c;
                n_rise++;
                hi = 0;
            end
            if (ws_a) hi++;
            if (!ws_a && prev) begin
                k = n_rise - 1;
                if (k == 0) hi0 = hi;
                if (k == 1) hi1 = hi;
                if (k < 24) bits_got[23 - k] = (hi == 80);
                if (hi != 40 && hi != 80) bad_bits++;
            end
            if (done_a) begin
                n_done++;
                done_cyc = c;
            end
            prev = ws_a;
        end
        start_a = 1'b0;
    endtask

    int   prev_addr, addr_err, max_addr, n_done_b, done_cyc_b, rises_b, high_b;
    logic prev_b;

    initial begin
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy_a, 0);
        chk("reset_done", done_a, 0);
        chk("reset_addr", rd_addr_a, 0);
        chk("reset_line", ws_a, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single start pulse: full 24-bit frame.
        start_a = 1'b1;
        cap_a(8004, 1'b0);
        chk("f1_busy_load", busy0, 1);
        chk("f1_rise0", rise0, 1);
        chk("f1_hi_bit0", hi0, 40);
        chk("f1_hi_bit1", hi1, 80);
        chk("f1_nbits", n_rise, 24);
        chk("f1_data", bits_got, 32'h4120C0);
        chk("f1_bit_timing", bad_bits, 0);
        chk("f1_ndone", n_done, 1);
        chk("f1_done_cyc", done_cyc, 8003);
        chk("f1_addr_end", rd_addr_a, 0);
`ifdef WS2812_AUTO_REFRESH_EN
        chk("f1_busy_end", busy_a, 1);
        cap_a(8003, 1'b0);
        chk("f2_nbits", n_rise, 24);
        chk("f2_data", bits_got, 32'h4120C0);
        chk("f2_ndone", n_done, 1);
        chk("f2_done_cyc", done_cyc, 8002);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
`else
        chk("f1_busy_end", busy_a, 0);

        // Start held high for the whole frame: no restart, one done.
        @(negedge clk);
        start_a = 1'b1;
        cap_a(8004, 1'b1);
        chk("hold_nbits", n_rise, 24);
        chk("hold_ndone", n_done, 1);
        chk("hold_done_cyc", done_cyc, 8003);
        @(negedge clk);
        chk("hold_idle_after", busy_a, 0);

        // Reset during bit 10 (a '1' bit, line high).
        @(negedge clk);
        start_a = 1'b1;
        for (int c = 0; c <= 1255; c++) begin
            @(negedge clk);
            start_a = 1'b0;
        end
        chk("rst_pre_line", ws_a, 1);
        rst = 1'b0;
        #1;
        chk("rst_line", ws_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_addr", rd_addr_a, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        cap_a(8100, 1'b0);
        chk("rst_no_resume_bits", n_rise, 0);
        chk("rst_no_done", n_done, 0);
        chk("rst_idle", busy_a, 0);
        start_a = 1'b1;
        cap_a(8004, 1'b0);
        chk("re_rise0", rise0, 1);
        chk("re_data", bits_got, 32'h4120C0);
        chk("re_timing", bad_bits, 0);
        chk("re_ndone", n_done, 1);
        chk("re_done_cyc", done_cyc, 8003);
`endif

        // 85 LEDs with fast timing: addresses 0..254 then 0.
        prev_addr = 0; addr_err = 0; max_addr = 0; n_done_b = 0; done_cyc_b = -1;
        rises_b = 0; high_b = 0; prev_b = 1'b0;
        @(negedge clk);
        start_b = 1'b1;
        for (int c = 0; c <= 8425; c++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (int'(rd_addr_b) != prev_addr) begin
                if (rd_addr_b == 8'd0) begin
                    if (prev_addr != 254) addr_err++;
                end else if (int'(rd_addr_b) != prev_addr + 1) begin
                    addr_err++;
                end
                prev_addr = int'(rd_addr_b);
                if (prev_addr > max_addr) max_addr = prev_addr;
            end
            if (ws_b && !prev_b) rises_b++;
            if (ws_b) high_b++;
            if (done_b) begin
                n_done_b++;
                done_cyc_b = c;
            end
            prev_b = ws_b;
        end
        chk("b_addr_seq", addr_err, 0);
        chk("b_max_addr", max_addr, 254);
        chk("b_addr_end", rd_addr_b, 0);
        chk("b_nbits", rises_b, 2040);
        chk("b_high_cycles", high_b, 3056);
        chk("b_ndone", n_done_b, 1);
        chk("b_done_cyc", done_cyc_b, 8425);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
